// File: rtl/axil_rd_if.sv
// AXI4-lite read channels (AR + R) as one bundle.
// The master modport drives requests and receives responses; the slave modport is the reverse.
interface axil_rd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_fifo_rd.sv
// AXI4-lite read-path buffer: AR FIFO and R FIFO, with AR issue gated so that every
// in-flight read already owns an R FIFO slot.
module axil_fifo_rd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int AR_DEPTH   = 4,
    parameter int R_DEPTH    = 4,
    parameter int R_RESERVE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    axil_rd_if.slave                 s_axil,
    axil_rd_if.master                m_axil,
    output logic [$clog2(AR_DEPTH):0] ar_count,
    output logic [$clog2(R_DEPTH):0]  r_count,
    output logic [$clog2(R_DEPTH):0]  outstanding
);
    localparam int ARPW = $clog2(AR_DEPTH);
    localparam int RPW  = $clog2(R_DEPTH);
    localparam int ARW  = ADDR_WIDTH + 3;
    localparam int RW   = DATA_WIDTH + 2;

    logic [ARW-1:0]  ar_mem_q [AR_DEPTH];
    logic [RW-1:0]   r_mem_q  [R_DEPTH];
    logic [ARPW:0]   ar_wptr_q, ar_wptr_d, ar_rptr_q, ar_rptr_d;
    logic [RPW:0]    r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
    logic [RPW:0]    outst_q, outst_d;
    logic [RPW+1:0]  r_committed;
    logic            ar_full, ar_empty, r_full, r_empty, issue_ok;
    logic            ar_push, ar_pop, r_push, r_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign ar_full  = (ar_wptr_q[ARPW] != ar_rptr_q[ARPW]) &&
                      (ar_wptr_q[ARPW-1:0] == ar_rptr_q[ARPW-1:0]);
    assign ar_empty = (ar_wptr_q == ar_rptr_q);
    assign r_full   = (r_wptr_q[RPW] != r_rptr_q[RPW]) &&
                      (r_wptr_q[RPW-1:0] == r_rptr_q[RPW-1:0]);
    assign r_empty  = (r_wptr_q == r_rptr_q);

    assign ar_count    = ar_wptr_q - ar_rptr_q;
    assign r_count     = r_wptr_q - r_rptr_q;
    assign outstanding = outst_q;

    assign r_committed = {1'b0, r_count} + {1'b0, outst_q};
    assign issue_ok    = (R_RESERVE == 0) || (r_committed < (RPW+2)'(R_DEPTH));

    assign s_axil.arready = !rst && !ar_full;
    assign m_axil.arvalid = !ar_empty && issue_ok;
    assign {m_axil.arprot, m_axil.araddr} = ar_mem_q[ar_rptr_q[ARPW-1:0]];

    // With reservation every returning beat already owns a slot, so the R side never stalls.
    assign m_axil.rready = !rst && ((R_RESERVE != 0) || !r_full);
    assign s_axil.rvalid = !r_empty;
    assign {s_axil.rresp, s_axil.rdata} = r_mem_q[r_rptr_q[RPW-1:0]];

    assign ar_push = s_axil.arvalid && s_axil.arready;
    assign ar_pop  = m_axil.arvalid && m_axil.arready;
    assign r_push  = m_axil.rvalid && m_axil.rready;
    assign r_pop   = s_axil.rvalid && s_axil.rready;

    always_comb begin
        ar_wptr_d = ar_wptr_q + {{ARPW{1'b0}}, ar_push};
        ar_rptr_d = ar_rptr_q + {{ARPW{1'b0}}, ar_pop};
        r_wptr_d  = r_wptr_q + {{RPW{1'b0}}, r_push};
        r_rptr_d  = r_rptr_q + {{RPW{1'b0}}, r_pop};
        outst_d   = outst_q;
        if (ar_pop && !r_push && (outst_q != (RPW+1)'(R_DEPTH))) begin
            outst_d = outst_q + 1'b1;
        end else if (!ar_pop && r_push && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_wptr_q <= '0;
            ar_rptr_q <= '0;
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            outst_q   <= '0;
        end else begin
            ar_wptr_q <= ar_wptr_d;
            ar_rptr_q <= ar_rptr_d;
            r_wptr_q  <= r_wptr_d;
            r_rptr_q  <= r_rptr_d;
            outst_q   <= outst_d;
        end
    end

    // Storage is deliberately unreset; its contents only matter behind a valid.
    always_ff @(posedge clk) begin
        if (ar_push) ar_mem_q[ar_wptr_q[ARPW-1:0]] <= {s_axil.arprot, s_axil.araddr};
        if (r_push)  r_mem_q[r_wptr_q[RPW-1:0]]    <= {m_axil.rresp, m_axil.rdata};
    end
endmodule

// File: tb/tb_axil_fifo_rd.sv
// Bench for axil_fifo_rd: directed vector table, streaming and random runs against a
// queue-based model, and an asynchronous mid-operation reset.
module tb_axil_fifo_rd;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int ARD = 4;
    localparam int RD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axil_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
    axil_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();
    logic [$clog2(ARD):0] ar_count;
    logic [$clog2(RD):0]  r_count;
    logic [$clog2(RD):0]  outstanding;

    axil_fifo_rd #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AR_DEPTH(ARD), .R_DEPTH(RD), .R_RESERVE(1)
    ) dut (
        .clk(clk), .rst(rst), .s_axil(s_if), .m_axil(m_if),
        .ar_count(ar_count), .r_count(r_count), .outstanding(outstanding)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic set_in(input logic arv, input logic [31:0] addr, input logic marr,
                          input logic mrv, input logic [31:0] mdata, input logic [1:0] mresp,
                          input logic srr);
        s_if.arvalid = arv;
        s_if.araddr  = addr;
        s_if.arprot  = addr[4:2];
        m_if.arready = marr;
        m_if.rvalid  = mrv;
        m_if.rdata   = mdata;
        m_if.rresp   = mresp;
        s_if.rready  = srr;
    endtask

    // Model state: pending ARs in the FIFO, issued-but-unanswered reads, buffered responses.
    logic [34:0] arq [$];
    logic [33:0] pend[$];
    logic [33:0] rq  [$];
    int beats, first_beat, last_beat, accepted, req_left;

    task automatic do_reset(input bit check);
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        if (check) begin
            chk("rst_ar_count", ar_count, 0);
            chk("rst_r_count", r_count, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_s_arready", s_if.arready, 0);
            chk("rst_m_rready", m_if.rready, 0);
            chk("rst_s_rvalid", s_if.rvalid, 0);
            chk("rst_m_arvalid", m_if.arvalid, 0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("rel_s_arready", s_if.arready, 1);
            chk("rel_m_rready", m_if.rready, 1);
        end
        @(posedge clk); #1;
        arq.delete(); pend.delete(); rq.delete();
    endtask

    task automatic run_model(input int ncyc, input int p_arv, input int p_marr,
                             input int p_mrv, input int p_srr);
        logic exp_marv, s_push, m_ar, m_r, s_r;
        beats = 0; first_beat = -1; last_beat = -1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            s_if.arvalid = (req_left > 0) && (($urandom % 100) < p_arv);
            s_if.araddr  = {$urandom, 2'b00};
            s_if.arprot  = 3'($urandom);
            m_if.arready = ($urandom % 100) < p_marr;
            m_if.rvalid  = (pend.size() != 0) && (($urandom % 100) < p_mrv);
            {m_if.rresp, m_if.rdata} = (pend.size() != 0) ? pend[0] : 34'h0;
            s_if.rready  = ($urandom % 100) < p_srr;
            @(negedge clk);
            exp_marv = (arq.size() != 0) && ((rq.size() + pend.size()) < RD);
            chk("ar_count", ar_count, arq.size());
            chk("r_count", r_count, rq.size());
            chk("outstanding", outstanding, pend.size());
            chk("outst_bound", outstanding <= RD, 1);
            chk("s_arready", s_if.arready, arq.size() < ARD);
            chk("m_arvalid", m_if.arvalid, exp_marv);
            if (exp_marv) chk("m_ar_head", {m_if.arprot, m_if.araddr}, arq[0]);
            chk("s_rvalid", s_if.rvalid, rq.size() != 0);
            if (rq.size() != 0) chk("s_r_head", {s_if.rresp, s_if.rdata}, rq[0]);
            chk("m_rready", m_if.rready, 1);
            chk("rfull_with_rvalid", m_if.rvalid && (r_count == RD), 0);
            @(posedge clk);
            s_push = s_if.arvalid && (arq.size() < ARD);
            m_ar   = m_if.arready && exp_marv;
            m_r    = m_if.rvalid;
            s_r    = s_if.rready && (rq.size() != 0);
            if (s_r) begin
                void'(rq.pop_front());
                beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            if (m_r) rq.push_back(pend.pop_front());
            if (m_ar) begin
                void'(arq.pop_front());
                pend.push_back({2'($urandom), 32'($urandom)});
            end
            if (s_push) begin
                arq.push_back({s_if.arprot, s_if.araddr});
                req_left--;
                accepted++;
            end
            #1;
        end
    endtask

    typedef struct {
        logic arv; logic [31:0] addr; logic marr; logic mrv; logic [31:0] mdata;
        logic [1:0] mresp; logic srr;
        int arc; int rc; int oc; logic sarr; logic marv; logic [31:0] maddr;
        logic srv; logic [31:0] sdata; logic [1:0] sresp;
    } vec_t;
    vec_t vt[23];

    initial begin
        //          arv addr      marr mrv mdata  resp srr | arc rc oc sarr marv maddr    srv sdata  sresp
        vt[0]  = '{1, 32'h100, 0, 0, 32'h0,  0, 0,  0, 0, 0, 1, 0, 32'h0,   0, 32'h0,  0};
        vt[1]  = '{1, 32'h104, 0, 0, 32'h0,  0, 0,  1, 0, 0, 1, 1, 32'h100, 0, 32'h0,  0};
        vt[2]  = '{1, 32'h108, 0, 0, 32'h0,  0, 0,  2, 0, 0, 1, 1, 32'h100, 0, 32'h0,  0};
        vt[3]  = '{1, 32'h10C, 0, 0, 32'h0,  0, 0,  3, 0, 0, 1, 1, 32'h100, 0, 32'h0,  0};
        vt[4]  = '{1, 32'h110, 0, 0, 32'h0,  0, 0,  4, 0, 0, 0, 1, 32'h100, 0, 32'h0,  0};
        vt[5]  = '{1, 32'h110, 1, 0, 32'h0,  0, 0,  4, 0, 0, 0, 1, 32'h100, 0, 32'h0,  0};
        vt[6]  = '{1, 32'h110, 1, 0, 32'h0,  0, 0,  3, 0, 1, 1, 1, 32'h104, 0, 32'h0,  0};
        vt[7]  = '{0, 32'h0,   1, 0, 32'h0,  0, 0,  3, 0, 2, 1, 1, 32'h108, 0, 32'h0,  0};
        vt[8]  = '{0, 32'h0,   1, 0, 32'h0,  0, 0,  2, 0, 3, 1, 1, 32'h10C, 0, 32'h0,  0};
        vt[9]  = '{0, 32'h0,   1, 0, 32'h0,  0, 0,  1, 0, 4, 1, 0, 32'h0,   0, 32'h0,  0};
        vt[10] = '{0, 32'h0,   1, 1, 32'hA0, 0, 0,  1, 0, 4, 1, 0, 32'h0,   0, 32'h0,  0};
        vt[11] = '{0, 32'h0,   1, 1, 32'hA1, 0, 0,  1, 1, 3, 1, 0, 32'h0,   1, 32'hA0, 0};
        vt[12] = '{0, 32'h0,   1, 1, 32'hA2, 2, 0,  1, 2, 2, 1, 0, 32'h0,   1, 32'hA0, 0};
        vt[13] = '{0, 32'h0,   1, 1, 32'hA3, 0, 0,  1, 3, 1, 1, 0, 32'h0,   1, 32'hA0, 0};
        vt[14] = '{0, 32'h0,   1, 0, 32'h0,  0, 0,  1, 4, 0, 1, 0, 32'h0,   1, 32'hA0, 0};
        vt[15] = '{0, 32'h0,   1, 0, 32'h0,  0, 1,  1, 4, 0, 1, 0, 32'h0,   1, 32'hA0, 0};
        vt[16] = '{0, 32'h0,   1, 0, 32'h0,  0, 1,  1, 3, 0, 1, 1, 32'h110, 1, 32'hA1, 0};
        vt[17] = '{0, 32'h0,   1, 0, 32'h0,  0, 1,  0, 2, 1, 1, 0, 32'h0,   1, 32'hA2, 2};
        vt[18] = '{0, 32'h0,   1, 0, 32'h0,  0, 1,  0, 1, 1, 1, 0, 32'h0,   1, 32'hA3, 0};
        vt[19] = '{0, 32'h0,   1, 0, 32'h0,  0, 1,  0, 0, 1, 1, 0, 32'h0,   0, 32'h0,  0};
        vt[20] = '{0, 32'h0,   1, 1, 32'hA4, 3, 0,  0, 0, 1, 1, 0, 32'h0,   0, 32'h0,  0};
        vt[21] = '{0, 32'h0,   1, 0, 32'h0,  0, 1,  0, 1, 0, 1, 0, 32'h0,   1, 32'hA4, 3};
        vt[22] = '{0, 32'h0,   0, 0, 32'h0,  0, 0,  0, 0, 0, 1, 0, 32'h0,   0, 32'h0,  0};

        do_reset(1);

        for (int i = 0; i < 23; i++) begin
            set_in(vt[i].arv, vt[i].addr, vt[i].marr, vt[i].mrv, vt[i].mdata, vt[i].mresp,
                   vt[i].srr);
            @(negedge clk);
            chk($sformatf("v%0d_ar_count", i), ar_count, vt[i].arc);
            chk($sformatf("v%0d_r_count", i), r_count, vt[i].rc);
            chk($sformatf("v%0d_outstanding", i), outstanding, vt[i].oc);
            chk($sformatf("v%0d_s_arready", i), s_if.arready, vt[i].sarr);
            chk($sformatf("v%0d_m_arvalid", i), m_if.arvalid, vt[i].marv);
            if (vt[i].marv) begin
                chk($sformatf("v%0d_m_araddr", i), m_if.araddr, vt[i].maddr);
                chk($sformatf("v%0d_m_arprot", i), m_if.arprot, vt[i].maddr[4:2]);
            end
            chk($sformatf("v%0d_s_rvalid", i), s_if.rvalid, vt[i].srv);
            if (vt[i].srv) begin
                chk($sformatf("v%0d_s_rdata", i), s_if.rdata, vt[i].sdata);
                chk($sformatf("v%0d_s_rresp", i), s_if.rresp, vt[i].sresp);
            end
            chk($sformatf("v%0d_m_rready", i), m_if.rready, 1);
            @(posedge clk); #1;
        end

        // Streaming: 100 requests with every ready high; beats land on cycles 3..102.
        do_reset(0);
        req_left = 100; accepted = 0;
        run_model(110, 100, 100, 100, 100);
        chk("stream_beats", beats, 100);
        chk("stream_first", first_beat, 3);
        chk("stream_last", last_beat, 102);

        // Random backpressure, then a drain with all readies high.
        do_reset(0);
        req_left = 1 << 30; accepted = 0;
        run_model(10000, 70, 55, 65, 50);
        chk("rand_some_beats", beats > 100, 1);
        req_left = 0;
        begin
            int total;
            total = beats;
            run_model(60, 0, 100, 100, 100);
            total += beats;
            chk("rand_all_returned", total, accepted);
        end
        chk("drain_empty", {ar_count, r_count, outstanding}, 0);

        // Asynchronous reset with ar_count=2, r_count=3 in flight.
        do_reset(0);
        for (int k = 0; k < 6; k++) begin
            set_in(1, 32'h200 + 32'(4 * k), (k < 5), 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 1, 32'hB0 + 32'(k), 2'(k), 0);
            @(posedge clk); #1;
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_ar_count", ar_count, 2);
        chk("pre_r_count", r_count, 3);
        chk("pre_outstanding", outstanding, 1);
        chk("pre_s_rvalid", s_if.rvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_s_rvalid", s_if.rvalid, 0);
        chk("arst_m_arvalid", m_if.arvalid, 0);
        chk("arst_ar_count", ar_count, 0);
        chk("arst_r_count", r_count, 0);
        chk("arst_outstanding", outstanding, 0);
        chk("arst_s_arready", s_if.arready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arel_s_arready", s_if.arready, 1);
        chk("arel_m_rready", m_if.rready, 1);
        chk("arel_counts", {ar_count, r_count, outstanding}, 0);
        chk("arel_s_rvalid", s_if.rvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
